pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register, successor to the fixed 32-bit fetch/decode latch. Carries a WIDTH-bit payload with a valid bit, valid/ready handshake, stall hold and flush-to-bubble. It can optionally add a one-entry skid buffer, which removes the combinational path from ready_in to ready_out. It also keeps a saturating stall-cycle counter for performance debug. One instance is placed between each pair of CPU pipeline stages (IF/ID, ID/EX, ...).

Parameters:
WIDTH, 64, payload width in bits (for IF/ID: instr + npc = 64).
SKID, 1, 1 = two-entry (main + skid) with registered ready_out; 0 = single entry, combinational ready_out.
BUBBLE, {WIDTH{1'b0}}, payload value loaded on reset/flush (all-zero = MIPS sll $0 nop).
CNT_W, 16, stall counter width.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-low reset.
valid_in  in  1  upstream beat present.
data_in  in  WIDTH  upstream payload.
ready_out  out  1  stage can accept a beat this cycle.
valid_out  out  1  downstream beat present.
data_out  out  WIDTH  downstream payload (main register).
ready_in  in  1  downstream accepts.
stall  in  1  hazard-unit hold; when 1 the stage behaves as if ready_in=0.
flush  in  1  synchronous kill of all held beats and the incoming beat.
stall_cnt  out  CNT_W  saturating count of cycles with valid_out=1 and the beat not advancing.
stall_cnt_clr  in  1  synchronous clear of stall_cnt.

Behaviour:
- advance = valid_out & ready_in & ~stall. accept = valid_in & ready_out.
- Reset (reset=0, async): valid_out=0, data_out=BUBBLE, skid empty (skid_valid=0, skid_data=BUBBLE), stall_cnt=0. With SKID=1, ready_out=1 during and after reset. The release edge takes effect on the first posedge with reset=1.
- Latency: 1 cycle from accept to valid_out when the stage is empty or advancing. Throughput is 1 beat/cycle with no bubbles while ready_in=1 and stall=0.
- SKID=0:
  - ready_out = ~valid_out | (ready_in & ~stall).
  - On accept, main <= data_in, valid <= 1.
  - On advance without accept, valid <= 0 and data is held.
  - Otherwise main is held (the same behaviour as the original stall hold).
- SKID=1, states by occupancy: EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid). ready_out = ~skid_valid, registered.
  - EMPTY: accept -> ONE (main loaded).
  - ONE: accept & advance -> ONE (main reloaded). accept & ~advance -> FULL (beat into skid). ~accept & advance -> EMPTY. Otherwise hold.
  - FULL: advance -> ONE (skid moves to main, skid cleared, ready_out=1 next cycle). Otherwise hold. accept cannot occur in FULL.
  - Order is preserved: the skid entry is always younger than main.
- flush (priority over everything except reset): next cycle valid_out=0, skid empty, data_out=BUBBLE, skid_data=BUBBLE.
  - A beat accepted in the flush cycle is discarded; upstream still sees its handshake complete.
  - A beat that advances in the flush cycle is considered delivered. Downstream is responsible for its own flush.
- flush and stall together: flush wins.
- stall_cnt:
  - Increments when valid_out & ~advance & ~flush.
  - Saturates at all-ones; never wraps.
  - stall_cnt_clr has priority over increment (result 0).
- data_out changes only on a load, skid transfer, flush or reset. It never glitches while valid_out is held.

Decomposition:
- Shared package cpu_pipe_pkg:
  - localparam NOP_INSTR = 32'h0000_0000.
  - IF_ID_W = 64 and ID_EX_W payload widths.
  - pipe_occ enum {EMPTY, ONE, FULL}.
- Sub-module pipe_skid_slot: one WIDTH-bit register plus valid, with load/clear/flush. It is instantiated twice when SKID=1 (main, skid) and once when SKID=0. Occupancy and control logic stay in the top.

Test Plan:
1. Reset/basic flow. Release reset with SKID=1, ready_in=1. Push 0x1111_0001..0x1111_0004 on consecutive cycles. Required: data_out shows each beat one cycle later in order, ready_out is 1 throughout, stall_cnt=0.
2. Stall hold. Load beat 0xAAAA and assert stall for 3 cycles with valid_in=1 carrying 0xBBBB, then 0xCCCC. Required:
   - 0xBBBB goes to skid and ready_out drops to 0 the next cycle.
   - data_out holds 0xAAAA and stall_cnt=3.
   - After stall drops, 0xAAAA, 0xBBBB and 0xCCCC come out in order with none lost or duplicated.
3. Flush. With FULL state (main 0x10, skid 0x20), assert flush with valid_in=1 data 0x30. Required: next cycle valid_out=0, data_out=BUBBLE, ready_out=1, and 0x30 is never seen downstream.
4. Async reset mid-operation. Assert reset between clock edges while FULL. Required: valid_out=0 and stall_cnt=0 immediately, before the next edge, and ready_out=1.
5. SKID=0 instance. Set ready_in=0 with main valid holding 0x55. Required:
   - ready_out=0 in the same cycle.
   - Raising ready_in raises ready_out combinationally, and the new beat loads on that edge.
6. Counter saturation and clear. With CNT_W=4, stall for 20 cycles. Required: stall_cnt reads 15 and stays at 15. stall_cnt_clr during a stall gives 0 next cycle.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared types and widths for the CPU inter-stage pipeline registers.
package cpu_pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int IF_ID_W = 64;   // instr + npc
    localparam int ID_EX_W = 144;  // npc, rs, rt, imm (32 each) + 16 control bits

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_occ;

    function automatic pipe_occ occ_of(input logic main_v, input logic skid_v);
        pipe_occ occ;
        occ = EMPTY;
        if (skid_v) begin
            occ = FULL;
        end else if (main_v) begin
            occ = ONE;
        end
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One payload register plus valid bit. Flush beats load, load beats clear;
// clear drops the valid bit but keeps the payload so data_out never glitches.
module pipe_skid_slot
    import cpu_pipe_pkg::*;
#(
    parameter int               WIDTH  = IF_ID_W,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             clear_i,
    input  logic             flush_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            data_d  = BUBBLE;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= BUBBLE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, stall, flush,
// optional skid entry and a saturating stall-cycle counter.
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are 1; valid must not depend on ready. Downstream "ready"
// is ready_in & ~stall.
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int               WIDTH  = IF_ID_W,
    parameter bit               SKID   = 1'b1,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             ready_in,
    input  logic             stall,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    input  logic             stall_cnt_clr,
    output pipe_occ          occ_o
);

    logic             advance;
    logic             accept;
    logic             main_v;
    logic [WIDTH-1:0] main_data;
    logic             main_load;
    logic             main_clear;
    logic [WIDTH-1:0] main_in;
    logic             skid_v;
    logic [WIDTH-1:0] skid_data;

    assign advance = valid_out & ready_in & ~stall;
    assign accept  = valid_in & ready_out;

    generate
        if (SKID) begin : g_skid
            logic skid_load;
            logic skid_clear;

            // The skid entry is always younger than main, so it drains into main.
            always_comb begin
                main_load  = 1'b0;
                main_clear = 1'b0;
                main_in    = data_in;
                skid_load  = 1'b0;
                skid_clear = 1'b0;
                if (skid_v) begin
                    if (advance) begin
                        main_load  = 1'b1;
                        main_in    = skid_data;
                        skid_clear = 1'b1;
                    end
                end else if (main_v) begin
                    if (accept && advance) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                    end else if (advance) begin
                        main_clear = 1'b1;
                    end
                end else if (accept) begin
                    main_load = 1'b1;
                end
            end

            pipe_skid_slot #(
                .WIDTH  (WIDTH),
                .BUBBLE (BUBBLE)
            ) u_skid (
                .clk     (clk),
                .rst_n   (reset),
                .load_i  (skid_load),
                .data_i  (data_in),
                .clear_i (skid_clear),
                .flush_i (flush),
                .valid_o (skid_v),
                .data_o  (skid_data)
            );

            // Driven straight from a flop, breaking the ready_in -> ready_out path.
            assign ready_out = ~skid_v;
        end else begin : g_single
            assign skid_v    = 1'b0;
            assign skid_data = BUBBLE;
            assign ready_out = ~main_v | (ready_in & ~stall);

            always_comb begin
                main_in    = data_in;
                main_load  = accept;
                main_clear = advance & ~accept;
            end
        end
    endgenerate

    pipe_skid_slot #(
        .WIDTH  (WIDTH),
        .BUBBLE (BUBBLE)
    ) u_main (
        .clk     (clk),
        .rst_n   (reset),
        .load_i  (main_load),
        .data_i  (main_in),
        .clear_i (main_clear),
        .flush_i (flush),
        .valid_o (main_v),
        .data_o  (main_data)
    );

    assign valid_out = main_v;
    assign data_out  = main_data;
    assign occ_o     = occ_of(main_v, skid_v);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_cnt_clr) begin
            stall_cnt_d = '0;
        end else if (valid_out && !advance && !flush && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
